// File: rtl/registered_demultiplexer.sv
// Four-channel demultiplexer with per-channel holding registers and valid/ack handshake.
// Optional feature: define DEMUX_ROUND_ROBIN_EN to select channels from an internal pointer instead of addr1/addr0.
module registered_demultiplexer #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             addr0,
  input  logic             addr1,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic             valid0,
  output logic             valid1,
  output logic             valid2,
  output logic             valid3,
  input  logic             ack0,
  input  logic             ack1,
  input  logic             ack2,
  input  logic             ack3,
  output logic             err
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } chan_state_t;

  chan_state_t      r_state     [4];
  chan_state_t      w_state_nxt [4];
  logic [WIDTH-1:0] r_out       [4];
  logic             r_err;
  logic [1:0]       w_sel;
  logic [3:0]       w_ack;
  logic [3:0]       w_valid;
  logic [3:0]       w_load;
  logic             w_ready;
  logic             w_accept;
  logic             w_drop;

  assign w_ack   = {ack3, ack2, ack1, ack0};
  assign w_valid = {r_state[3] == FULL, r_state[2] == FULL,
                    r_state[1] == FULL, r_state[0] == FULL};

`ifdef DEMUX_ROUND_ROBIN_EN
  logic [1:0] r_ptr;
  logic       w_unused_addr;

  assign w_unused_addr = addr0 ^ addr1;
  assign w_sel         = r_ptr;

  // Pointer advances only on a real accept so drops and idle cycles retry the same channel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= 2'd0;
    end else if (w_accept) begin
      r_ptr <= r_ptr + 2'd1;
    end else begin
      r_ptr <= r_ptr;
    end
  end
`else
  assign w_sel = {addr1, addr0};
`endif

  // An ack on the selected channel frees its slot in the same cycle, giving pass-through.
  assign w_ready  = !w_valid[w_sel] | w_ack[w_sel];
  assign w_accept = in_valid & w_ready;
  assign w_drop   = in_valid & ~w_ready;

  always_comb begin
    w_load = 4'b0000;
    if (w_accept) begin
      w_load[w_sel] = 1'b1;
    end else begin
      w_load = 4'b0000;
    end
    for (int i = 0; i < 4; i++) begin
      w_state_nxt[i] = r_state[i];
      case (r_state[i])
        EMPTY: begin
          if (w_load[i]) w_state_nxt[i] = FULL;
          else           w_state_nxt[i] = EMPTY;
        end
        FULL: begin
          if (w_ack[i] && !w_load[i]) w_state_nxt[i] = EMPTY;
          else                        w_state_nxt[i] = FULL;
        end
        default: w_state_nxt[i] = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        r_state[i] <= EMPTY;
        r_out[i]   <= '0;
      end
      r_err <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        r_state[i] <= w_state_nxt[i];
        if (w_load[i]) r_out[i] <= in;
        else           r_out[i] <= r_out[i];
      end
      if (w_drop) r_err <= 1'b1;
      else        r_err <= r_err;
    end
  end

  assign in_ready = w_ready;
  assign out0     = r_out[0];
  assign out1     = r_out[1];
  assign out2     = r_out[2];
  assign out3     = r_out[3];
  assign valid0   = w_valid[0];
  assign valid1   = w_valid[1];
  assign valid2   = w_valid[2];
  assign valid3   = w_valid[3];
  assign err      = r_err;

endmodule

// File: tb/tb_registered_demultiplexer.sv
// Directed testbench for registered_demultiplexer; round-robin scenario runs when DEMUX_ROUND_ROBIN_EN is defined.
module tb_registered_demultiplexer;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   addr;
  logic [W-1:0] din;
  logic         in_valid;
  logic [3:0]   ack;
  wire          in_ready;
  wire          err;
  wire  [3:0]   v;
  wire  [W-1:0] o [4];
  int           errors = 0;
  int           checks = 0;

  registered_demultiplexer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .addr0(addr[0]), .addr1(addr[1]),
    .in(din), .in_valid(in_valid), .in_ready(in_ready),
    .out0(o[0]), .out1(o[1]), .out2(o[2]), .out3(o[3]),
    .valid0(v[0]), .valid1(v[1]), .valid2(v[2]), .valid3(v[3]),
    .ack0(ack[0]), .ack1(ack[1]), .ack2(ack[2]), .ack3(ack[3]),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; addr = 2'd0; din = 4'h0; in_valid = 1'b0; ack = 4'h0;
    #1;
    checks++; if (v !== 4'h0) begin errors++; $display("FAIL reset_valid: got %h expected 0", v); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (o[i] !== 4'h0) begin errors++; $display("FAIL reset_out%0d: got %h expected 0", i, o[i]); end
    end
    #2 reset = 1'b0;
    cycle();
  endtask

`ifndef DEMUX_ROUND_ROBIN_EN
  task automatic test_routing();
    for (int pass = 0; pass < 2; pass++) begin
      logic [W-1:0] d;
      d = (pass == 0) ? 4'h1 : 4'h0;
      for (int a = 0; a < 4; a++) begin
        addr = a[1:0]; din = d; in_valid = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL route_ready%0d: got %b expected 1", a, in_ready); end
        cycle();
      end
      in_valid = 1'b0;
      checks++; if (v !== 4'hF) begin errors++; $display("FAIL route_valid: got %h expected f", v); end
      for (int i = 0; i < 4; i++) begin
        checks++; if (o[i] !== d) begin errors++; $display("FAIL route_out%0d: got %h expected %h", i, o[i], d); end
      end
      ack = 4'hF;
      cycle();
      ack = 4'h0;
      checks++; if (v !== 4'h0) begin errors++; $display("FAIL route_acked: got %h expected 0", v); end
      checks++; if (o[2] !== d) begin errors++; $display("FAIL route_hold: got %h expected %h", o[2], d); end
    end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL route_err: got %b expected 0", err); end
  endtask

  task automatic test_backpressure();
    addr = 2'd2; din = 4'h5; in_valid = 1'b1;
    cycle();
    din = 4'hA;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b expected 0", in_ready); end
    cycle();
    in_valid = 1'b0;
    checks++; if (o[2] !== 4'h5) begin errors++; $display("FAIL bp_out2: got %h expected 5", o[2]); end
    checks++; if (v !== 4'h4) begin errors++; $display("FAIL bp_valid: got %h expected 4", v); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL bp_err: got %b expected 1", err); end
    repeat (5) cycle();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL bp_sticky: got %b expected 1", err); end
    // ack on an empty channel is ignored; acks on several channels act independently
    addr = 2'd0; din = 4'h7; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0; ack = 4'b0110;
    cycle();
    ack = 4'h0;
    checks++; if (v !== 4'h1) begin errors++; $display("FAIL multi_ack: got %h expected 1", v); end
    checks++; if (o[0] !== 4'h7) begin errors++; $display("FAIL multi_out0: got %h expected 7", o[0]); end
    ack = 4'h1;
    cycle();
    ack = 4'h0;
  endtask

  task automatic test_passthrough();
    addr = 2'd1; din = 4'h0; in_valid = 1'b1;
    cycle();
    din = 4'h1; ack = 4'b0010;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL pt_ready: got %b expected 1", in_ready); end
    cycle();
    in_valid = 1'b0; ack = 4'h0;
    checks++; if (o[1] !== 4'h1) begin errors++; $display("FAIL pt_out1: got %h expected 1", o[1]); end
    checks++; if (v !== 4'h2) begin errors++; $display("FAIL pt_valid: got %h expected 2", v); end
    ack = 4'b0010;
    cycle();
    ack = 4'h0;
    checks++; if (v !== 4'h0) begin errors++; $display("FAIL pt_drain: got %h expected 0", v); end
    checks++; if (o[1] !== 4'h1) begin errors++; $display("FAIL pt_hold: got %h expected 1", o[1]); end
  endtask

  task automatic test_reset_mid();
    addr = 2'd0; din = 4'h3; in_valid = 1'b1;
    cycle();
    addr = 2'd3; din = 4'hC;
    cycle();
    in_valid = 1'b0;
    reset = 1'b1;
    #2;
    checks++; if (v !== 4'h0) begin errors++; $display("FAIL mid_valid: got %h expected 0", v); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_err: got %b expected 0", err); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (o[i] !== 4'h0) begin errors++; $display("FAIL mid_out%0d: got %h expected 0", i, o[i]); end
    end
    reset = 1'b0;
    addr = 2'd3; din = 4'h9; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    checks++; if (v !== 4'h8) begin errors++; $display("FAIL mid_next_valid: got %h expected 8", v); end
    checks++; if (o[3] !== 4'h9) begin errors++; $display("FAIL mid_next_out3: got %h expected 9", o[3]); end
  endtask
`else
  task automatic test_round_robin();
    logic [W-1:0] d [5];
    d[0] = 4'h1; d[1] = 4'h0; d[2] = 4'h1; d[3] = 4'h0; d[4] = 4'h1;
    for (int k = 0; k < 5; k++) begin
      int c;
      c = k % 4;
      addr = 2'($urandom_range(0, 3)); din = d[k]; in_valid = 1'b1;
      ack = (k == 0) ? 4'h0 : (4'h1 << ((k - 1) % 4));
      cycle();
      checks++; if (v !== (4'h1 << c)) begin errors++; $display("FAIL rr_valid%0d: got %h expected %h", k, v, 4'h1 << c); end
      checks++; if (o[c] !== d[k]) begin errors++; $display("FAIL rr_out%0d: got %h expected %h", k, o[c], d[k]); end
    end
    in_valid = 1'b0; ack = 4'h0;
  endtask
`endif

  initial begin
    test_reset();
`ifndef DEMUX_ROUND_ROBIN_EN
    test_routing();
    test_backpressure();
    test_passthrough();
    test_reset_mid();
`else
    test_round_robin();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/registered_demultiplexer.md
REGISTERED_DEMULTIPLEXER -- requirements
Module: registered_demultiplexer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1, giving the data width of in and of each out channel.
REQ-002 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1: asynchronous, active-high reset.
REQ-004 Port addr0, input, 1: channel select LSB.
REQ-005 Port addr1, input, 1: channel select MSB; channel = {addr1,addr0}.
REQ-006 Port in, input, WIDTH: data to route.
REQ-007 Port in_valid, input, 1: in is offered this cycle.
REQ-008 Port in_ready, output, 1: the selected channel can accept this cycle.
REQ-009 Ports out0..out3, output, WIDTH each: per-channel holding registers.
REQ-010 Ports valid0..valid3, output, 1 each: the matching outN holds unconsumed data.
REQ-011 Ports ack0..ack3, input, 1 each: the consumer takes outN this cycle.
REQ-012 Port err, output, 1: sticky drop flag.

Function
REQ-013 Selected channel s SHALL be {addr1,addr0}: 00->0, 01->1, 10->2, 11->3.
REQ-014 in_ready SHALL be combinational: in_ready = !valid[s] | ack[s].
REQ-015 Accept = in_valid & in_ready; on accept, out[s] <= in and valid[s] <= 1 at the next edge (1-cycle latency).
REQ-016 ackN with validN=1 and no same-cycle accept into N SHALL clear validN at the next edge; outN SHALL hold its value.
REQ-017 A same-cycle ack[s] and accept into s SHALL load new data and leave valid[s]=1 (pass-through, no bubble).
REQ-018 ackN with validN=0 SHALL be ignored.
REQ-019 Non-selected channels SHALL be unaffected by in/in_valid; acks on several channels in one cycle SHALL each act independently.
REQ-020 in_valid=1 with in_ready=0 SHALL drop the data: no register changes, and err <= 1.
REQ-021 err SHALL stay 1 until reset.
REQ-022 Each channel SHALL behave as a 2-state FSM, EMPTY (valid=0) and FULL (valid=1):
  - EMPTY->FULL on accept.
  - FULL->EMPTY on ack without accept.
  - FULL->FULL on ack with accept.
  - Otherwise the state holds.

Reset
REQ-023 While reset=1, regardless of clk, the block SHALL force out0..out3=0, valid0..valid3=0, err=0, and the round-robin pointer (when compiled in) to 0.
REQ-024 Reset asserted mid-transfer SHALL discard all held data; the first edge after deassertion SHALL behave as from power-up.

Configuration
REQ-025 Macro DEMUX_ROUND_ROBIN_EN.
  - Defined: s SHALL come from an internal 2-bit pointer, and addr0/addr1 SHALL be ignored.
  - The pointer SHALL increment modulo 4 after each accept (3->0 wrap) and hold on drop or idle.
  - Undefined: s SHALL come from addr1/addr0, and no pointer logic SHALL exist.

Verification
REQ-026 Reset: assert reset with no clk edge -> all outN=0, validN=0, err=0 immediately.
REQ-027 Routing: for addr 00,01,10,11, send in=1 with in_valid=1 one cycle each, then acks held 0 ->
  - valid0..3 all 1 and out0..3 all 1;
  - repeat with in=0 after acking -> outN=0.
REQ-028 Back-pressure: channel 2 FULL, addr=10, in_valid=1, ack2=0 -> in_ready=0, out2 unchanged, err=1 next cycle, remaining 1 after 5 idle cycles.
REQ-029 Pass-through: channel 1 FULL with out1=0, addr=01, in=1, in_valid=1, ack1=1 -> in_ready=1, next edge out1=1 and valid1=1.
REQ-030 Reset mid-operation: channels 0 and 3 FULL, pulse reset between edges -> valid0..3=0 and out0..3=0; the next accept to channel 3 sets only valid3.
REQ-031 Round robin (DEMUX_ROUND_ROBIN_EN defined): 5 accepts of in=1,0,1,0,1, acking each channel the cycle after it fills ->
  - data lands in channels 0,1,2,3,0;
  - the 5th accept has out0=1;
  - addr inputs toggled randomly have no effect.
